// File: rtl/wb8_pkg.sv
// Shared definitions for the two-master 8-bit Wishbone arbiter.
// Holds the arbiter state encoding and the data returned on a forced termination.
package wb8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } wb8_state_e;

    localparam logic [7:0] WB8_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/wb8_bus_watchdog.sv
// Bus watchdog: counts consecutive unacknowledged strobe cycles and pulses o_fire
// when the count reaches TIMEOUT_CYCLES (0 disables it).
module wb8_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_stb,
    input  logic i_ack,
    output logic o_fire
);

    localparam logic [7:0] LIMIT   = 8'(TIMEOUT_CYCLES);
    localparam bit         ENABLED = (TIMEOUT_CYCLES != 0);

    logic [7:0] r_count;

    // The first strobe cycle sees a count of 0, so the fire lands TIMEOUT_CYCLES cycles later.
    assign o_fire = ENABLED && i_stb && (r_count == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_stb || i_ack || o_fire) begin
            // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
            r_count <= '0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/wb8_arbiter2.sv
// Round-robin arbiter giving two Wishbone masters whole CYC tenures on one slave bus,
// with a watchdog that force-acknowledges strobes no slave answers.
module wb8_arbiter2
    import wb8_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        M0_CYC_I,
    input  logic        M0_STB_I,
    input  logic        M0_WE_I,
    input  logic [31:0] M0_ADR_I,
    input  logic [7:0]  M0_DAT_I,
    output logic [7:0]  M0_DAT_O,
    output logic        M0_ACK_O,
    input  logic        M1_CYC_I,
    input  logic        M1_STB_I,
    input  logic        M1_WE_I,
    input  logic [31:0] M1_ADR_I,
    input  logic [7:0]  M1_DAT_I,
    output logic [7:0]  M1_DAT_O,
    output logic        M1_ACK_O,
    output logic        S_CYC_O,
    output logic        S_STB_O,
    output logic        S_WE_O,
    output logic [31:0] S_ADR_O,
    output logic [7:0]  S_DAT_O,
    input  logic [7:0]  S_DAT_I,
    input  logic        S_ACK_I,
    output logic [1:0]  O_grant,
    output logic        O_timeout
);

    wb8_state_e r_state;
    wb8_state_e w_next_state;
    logic       r_last;
    logic       w_stb_raw;
    logic       w_fire;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_next_state != IDLE) begin
                r_last <= (w_next_state == OWN1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (M0_CYC_I && M1_CYC_I) begin
                    w_next_state = r_last ? OWN0 : OWN1;
                end else if (M0_CYC_I) begin
                    w_next_state = OWN0;
                end else if (M1_CYC_I) begin
                    w_next_state = OWN1;
                end
            end
            OWN0:    if (!M0_CYC_I) w_next_state = IDLE;
            OWN1:    if (!M1_CYC_I) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Owner's strobe before the watchdog override; the watchdog must see it to fire.
    assign w_stb_raw = ((r_state == OWN0) && M0_CYC_I && M0_STB_I) ||
                       ((r_state == OWN1) && M1_CYC_I && M1_STB_I);

    wb8_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (CLK_I),
        .rst_n  (RST_I),
        .i_stb  (w_stb_raw),
        .i_ack  (S_ACK_I),
        .o_fire (w_fire)
    );

    assign O_timeout = w_fire;

    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        S_CYC_O  = 1'b0;
        S_STB_O  = 1'b0;
        S_WE_O   = 1'b0;
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        O_grant  = 2'b00;
        M0_ACK_O = 1'b0;
        M0_DAT_O = '0;
        M1_ACK_O = 1'b0;
        M1_DAT_O = '0;
        case (r_state)
            OWN0: begin
                S_CYC_O  = M0_CYC_I;
                S_STB_O  = w_stb_raw && !w_fire;
                S_WE_O   = M0_WE_I;
                S_ADR_O  = M0_ADR_I;
                S_DAT_O  = M0_DAT_I;
                O_grant  = 2'b01;
                M0_ACK_O = S_ACK_I || w_fire;
                M0_DAT_O = w_fire ? WB8_TIMEOUT_DATA : S_DAT_I;
            end
            OWN1: begin
                S_CYC_O  = M1_CYC_I;
                S_STB_O  = w_stb_raw && !w_fire;
                S_WE_O   = M1_WE_I;
                S_ADR_O  = M1_ADR_I;
                S_DAT_O  = M1_DAT_I;
                O_grant  = 2'b10;
                M1_ACK_O = S_ACK_I || w_fire;
                M1_DAT_O = w_fire ? WB8_TIMEOUT_DATA : S_DAT_I;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb8_arbiter2.sv
// Self-checking bench for wb8_arbiter2: two instances (watchdog 4 and disabled) share
// directed stimulus; a behavioural model is compared every cycle, plus literal checks.
module tb_wb8_arbiter2;

    localparam int T_A = 4;
    localparam int T_B = 0;

    typedef struct packed {
        logic [1:0]  grant;
        logic        s_cyc;
        logic        s_stb;
        logic        s_we;
        logic [31:0] s_adr;
        logic [7:0]  s_dat;
        logic        m0_ack;
        logic [7:0]  m0_dat;
        logic        m1_ack;
        logic [7:0]  m1_dat;
        logic        timeout;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_adr = '0;
    logic [7:0]  m0_dat = '0;
    logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_adr = '0;
    logic [7:0]  m1_dat = '0;
    logic [7:0]  s_dat_in = '0;
    logic        s_ack = 1'b0;

    logic [7:0]  a_m0_dat, a_m1_dat, a_s_dat, b_m0_dat, b_m1_dat, b_s_dat;
    logic        a_m0_ack, a_m1_ack, a_s_cyc, a_s_stb, a_s_we, a_timeout;
    logic        b_m0_ack, b_m1_ack, b_s_cyc, b_s_stb, b_s_we, b_timeout;
    logic [31:0] a_s_adr, b_s_adr;
    logic [1:0]  a_grant, b_grant;
    out_t        a_out, b_out;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb8_arbiter2 #(.TIMEOUT_CYCLES(T_A)) dut_a (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr),
        .M0_DAT_I(m0_dat), .M0_DAT_O(a_m0_dat), .M0_ACK_O(a_m0_ack),
        .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr),
        .M1_DAT_I(m1_dat), .M1_DAT_O(a_m1_dat), .M1_ACK_O(a_m1_ack),
        .S_CYC_O(a_s_cyc), .S_STB_O(a_s_stb), .S_WE_O(a_s_we), .S_ADR_O(a_s_adr),
        .S_DAT_O(a_s_dat), .S_DAT_I(s_dat_in), .S_ACK_I(s_ack),
        .O_grant(a_grant), .O_timeout(a_timeout)
    );

    wb8_arbiter2 #(.TIMEOUT_CYCLES(T_B)) dut_b (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr),
        .M0_DAT_I(m0_dat), .M0_DAT_O(b_m0_dat), .M0_ACK_O(b_m0_ack),
        .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr),
        .M1_DAT_I(m1_dat), .M1_DAT_O(b_m1_dat), .M1_ACK_O(b_m1_ack),
        .S_CYC_O(b_s_cyc), .S_STB_O(b_s_stb), .S_WE_O(b_s_we), .S_ADR_O(b_s_adr),
        .S_DAT_O(b_s_dat), .S_DAT_I(s_dat_in), .S_ACK_I(s_ack),
        .O_grant(b_grant), .O_timeout(b_timeout)
    );

    assign a_out = {a_grant, a_s_cyc, a_s_stb, a_s_we, a_s_adr, a_s_dat,
                    a_m0_ack, a_m0_dat, a_m1_ack, a_m1_dat, a_timeout};
    assign b_out = {b_grant, b_s_cyc, b_s_stb, b_s_we, b_s_adr, b_s_dat,
                    b_m0_ack, b_m0_dat, b_m1_ack, b_m1_dat, b_timeout};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 = bus idle, 1 = M0 owns, 2 = M1 owns; age = unanswered strobe cycles so far
    int own = 0;
    bit last_m1 = 1'b1;
    int age_a = 0;
    int age_b = 0;

    function automatic out_t model_out(int owner, int age, int t);
        out_t o;
        logic cyc, stb, fire;
        o = '0;
        if (owner != 0) begin
            cyc  = (owner == 1) ? m0_cyc : m1_cyc;
            stb  = cyc && ((owner == 1) ? m0_stb : m1_stb);
            fire = (t != 0) && stb && (age == t);
            o.grant   = (owner == 1) ? 2'b01 : 2'b10;
            o.s_cyc   = cyc;
            o.s_stb   = stb && !fire;
            o.s_we    = (owner == 1) ? m0_we : m1_we;
            o.s_adr   = (owner == 1) ? m0_adr : m1_adr;
            o.s_dat   = (owner == 1) ? m0_dat : m1_dat;
            o.timeout = fire;
            if (owner == 1) begin
                o.m0_ack = fire || s_ack;
                o.m0_dat = fire ? 8'hFF : s_dat_in;
            end else begin
                o.m1_ack = fire || s_ack;
                o.m1_dat = fire ? 8'hFF : s_dat_in;
            end
        end
        return o;
    endfunction

    function automatic int age_next(int owner, int age, int t);
        out_t o;
        o = model_out(owner, age, t);
        return (o.s_stb && !s_ack) ? ((age + 1) % 256) : 0;
    endfunction

    function automatic int own_next(int owner);
        if (owner == 0) begin
            if (m0_cyc && m1_cyc) return last_m1 ? 1 : 2;
            if (m0_cyc)           return 1;
            if (m1_cyc)           return 2;
            return 0;
        end
        if (owner == 1) return m0_cyc ? 1 : 0;
        return m1_cyc ? 2 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own     <= 0;
            last_m1 <= 1'b1;
            age_a   <= 0;
            age_b   <= 0;
        end else begin
            age_a <= age_next(own, age_a, T_A);
            age_b <= age_next(own, age_b, T_B);
            own   <= own_next(own);
            if (own == 0 && own_next(own) != 0) last_m1 <= (own_next(own) == 2);
        end
    end

    always @(negedge clk) begin
        check("model_t4", a_out, model_out(own, age_a, T_A));
        check("model_t0", b_out, model_out(own, age_b, T_B));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic drop_all();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        s_ack = 1'b0; s_dat_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    int pulses_a, pulses_b, acks_b;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_grant", 64'(a_grant), 64'h0);
        check("rst_s_cyc", 64'(a_s_cyc), 64'h0);
        check("rst_timeout", 64'(a_timeout), 64'h0);
        #1 rst_n = 1'b1;

        // M0 alone reads 0xFFFFF000, slave acks in the third strobe cycle
        step(); m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'hFFFF_F000; probe();
        check("rd_grant_n", 64'(a_grant), 64'h0);
        check("rd_stb_n", 64'(a_s_stb), 64'h0);
        step(); probe();
        check("rd_grant", 64'(a_grant), 64'h1);
        check("rd_stb", 64'(a_s_stb), 64'h1);
        check("rd_adr", 64'(a_s_adr), 64'hFFFF_F000);
        check("rd_ack_wait", 64'(a_m0_ack), 64'h0);
        step(); probe();
        check("rd_ack_wait2", 64'(a_m0_ack), 64'h0);
        step(); s_ack = 1'b1; s_dat_in = 8'h5A; probe();
        check("rd_ack", 64'(a_m0_ack), 64'h1);
        check("rd_dat", 64'(a_m0_dat), 64'h5A);
        check("rd_m1_ack", 64'(a_m1_ack), 64'h0);
        step(); drop_all(); probe();
        check("rd_drop_cyc", 64'(a_s_cyc), 64'h0);
        check("rd_drop_grant", 64'(a_grant), 64'h1);
        step(); probe();
        check("rd_idle", 64'(a_grant), 64'h0);

        // simultaneous requests after reset: strict alternation, M0 first
        do_reset();
        step();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0100;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0200;
        s_ack = 1'b1; s_dat_in = 8'hC3;
        probe();
        check("alt_grant_n", 64'(a_grant), 64'h0);
        for (int t = 0; t < 4; t++) begin
            step(); probe();
            check("alt_grant", 64'(a_grant), (t % 2 == 1) ? 64'h2 : 64'h1);
            check("alt_adr", 64'(a_s_adr), (t % 2 == 1) ? 64'h200 : 64'h100);
            step(); probe();
            check("alt_hold", 64'(a_grant), (t % 2 == 1) ? 64'h2 : 64'h1);
            step();
            if (t % 2 == 1) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
            else            begin m0_cyc = 1'b0; m0_stb = 1'b0; end
            probe();
            check("alt_drop_cyc", 64'(a_s_cyc), 64'h0);
            step();
            if (t < 3) begin
                if (t % 2 == 1) begin m1_cyc = 1'b1; m1_stb = 1'b1; end
                else            begin m0_cyc = 1'b1; m0_stb = 1'b1; end
            end
            probe();
            check("alt_gap", 64'(a_grant), 64'h0);
        end
        step(); drop_all();
        step(); step();

        // M1 holds CYC over four writes with STB toggling while M0 waits
        step(); m1_cyc = 1'b1; m1_we = 1'b1; probe();
        check("wr_grant_n", 64'(a_grant), 64'h0);
        step(); m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_3000; probe();
        check("wr_grant", 64'(a_grant), 64'h2);
        for (int w = 0; w < 4; w++) begin
            step(); m1_stb = 1'b1; m1_dat = 8'h10 + 8'(w); m1_adr = 32'h2000 + 32'(w); s_ack = 1'b1;
            probe();
            check("wr_grant_beat", 64'(a_grant), 64'h2);
            check("wr_s_we", 64'(a_s_we), 64'h1);
            check("wr_s_dat", 64'(a_s_dat), 64'h10 + 64'(w));
            check("wr_m1_ack", 64'(a_m1_ack), 64'h1);
            check("wr_m0_ack", 64'(a_m0_ack), 64'h0);
            step(); m1_stb = 1'b0; s_ack = 1'b0; probe();
            check("wr_gap_stb", 64'(a_s_stb), 64'h0);
            check("wr_grant_gap", 64'(a_grant), 64'h2);
        end
        step(); m1_cyc = 1'b0; m1_we = 1'b0; probe();
        check("wr_drop_cyc", 64'(a_s_cyc), 64'h0);
        step(); probe();
        check("wr_handover_idle", 64'(a_grant), 64'h0);
        step(); probe();
        check("wr_handover_m0", 64'(a_grant), 64'h1);
        step(); drop_all();
        step(); step();

        // watchdog: M0 strobes 0xFFFFFA00 with no ACK; fires on strobe cycles 5 and 10
        step(); m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'hFFFF_FA00; probe();
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 10) begin s_ack = 1'b1; s_dat_in = 8'h33; end
            probe();
            check("wd_ack", 64'(a_m0_ack), (k == 5 || k == 10) ? 64'h1 : 64'h0);
            check("wd_pulse", 64'(a_timeout), (k == 5 || k == 10) ? 64'h1 : 64'h0);
            check("wd_stb", 64'(a_s_stb), (k == 5 || k == 10) ? 64'h0 : 64'h1);
            check("wd_off_pulse", 64'(b_timeout), 64'h0);
            if (k == 5 || k == 10) check("wd_dat", 64'(a_m0_dat), 64'hFF);
        end

        // strobe held 300 cycles with no ACK: T=4 fires 60 times, T=0 never
        pulses_a = 0; pulses_b = 0; acks_b = 0;
        step(); s_ack = 1'b0; s_dat_in = '0;
        for (int i = 1; i <= 300; i++) begin
            probe();
            pulses_a += int'(a_timeout);
            pulses_b += int'(b_timeout);
            acks_b   += int'(b_m0_ack);
            if (i < 300) step();
        end
        check("hold_pulses_t4", 64'(pulses_a), 64'd60);
        check("hold_pulses_t0", 64'(pulses_b), 64'd0);
        check("hold_acks_t0", 64'(acks_b), 64'd0);
        step(); drop_all();
        step(); step();

        // reset asserted mid-tenure while M1 owns the bus
        step(); m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_4000; s_ack = 1'b1; s_dat_in = 8'h77;
        probe();
        step(); probe();
        check("mr_grant_before", 64'(a_grant), 64'h2);
        check("mr_ack_before", 64'(a_m1_ack), 64'h1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mr_grant", 64'(a_grant), 64'h0);
        check("mr_s_cyc", 64'(a_s_cyc), 64'h0);
        check("mr_m1_ack", 64'(a_m1_ack), 64'h0);
        check("mr_m0_ack", 64'(a_m0_ack), 64'h0);
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_5000;
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(); probe();
        check("mr_first_m0", 64'(a_grant), 64'h1);
        step(); drop_all();
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
